// File: rtl/bht_predictor_ctrl.sv
// rtl/bht_predictor_ctrl.sv - branch history table of 2-bit counters with init sweep, lookup and training
module bht_predictor_ctrl #(
  parameter int INDEX_BITS = 6,
  parameter int PC_LSB     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  output logic        ready,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  output logic        pred_out_valid,
  output logic [1:0]  pred_counter,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state, state_nxt;
  logic [INDEX_BITS-1:0]   init_idx;
  logic [INDEX_BITS-1:0]   pred_idx, upd_idx, wr_idx;
  logic [1:0]              table_q [ENTRIES];
  logic [1:0]              upd_cur, upd_new, wr_data;
  logic                    wr_en, run_ok, last_idx, bypass;
  logic                    unused_pc_bits;

  assign pred_idx = pred_pc[PC_LSB+INDEX_BITS-1:PC_LSB];
  assign upd_idx  = upd_pc[PC_LSB+INDEX_BITS-1:PC_LSB];
  // Upper PC bits alias by design; the word-offset bits carry no information.
  assign unused_pc_bits = ^{pred_pc[31:PC_LSB+INDEX_BITS], pred_pc[PC_LSB-1:0],
                            upd_pc[31:PC_LSB+INDEX_BITS], upd_pc[PC_LSB-1:0]};

  assign last_idx = (init_idx == INDEX_BITS'(ENTRIES - 1));
  // A clear in RUN drops any same-cycle lookup or update.
  assign run_ok   = (state == RUN) && !clear;
  assign ready    = (state == RUN);
  assign upd_cur  = table_q[upd_idx];
  assign bypass   = upd_valid && (upd_idx == pred_idx);

  // Saturating counter step for the training update.
  always_comb begin
    upd_new = upd_cur;
    if (upd_taken) begin
      if (upd_cur != 2'b11) upd_new = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_new = upd_cur - 2'b01;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  // Next state and table write port selection (sweep write wins in INIT).
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_idx    = upd_idx;
    wr_data   = upd_new;
    case (state)
      INIT: begin
        if (!clear) begin
          wr_en   = 1'b1;
          wr_idx  = init_idx;
          wr_data = 2'b01;
          if (last_idx) state_nxt = RUN;
        end
      end
      RUN: begin
        if (clear) state_nxt = INIT;
        else if (upd_valid) wr_en = 1'b1;
      end
      default: state_nxt = INIT;
    endcase
    if (reset) wr_en = 1'b0;
  end

  // Sweep pointer: advances in INIT, restarts on reset or clear.
  always_ff @(posedge clk) begin
    if (reset || clear)      init_idx <= '0;
    else if (state == INIT)  init_idx <= init_idx + 1'b1;
  end

  // Counter table storage; contents come only from the sweep or training.
  always_ff @(posedge clk) begin
    if (wr_en) table_q[wr_idx] <= wr_data;
  end

  // Registered lookup result with same-index update bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_out_valid <= 1'b0;
      pred_counter   <= 2'b00;
      pred_taken     <= 1'b0;
    end else begin
      pred_out_valid <= run_ok && pred_valid;
      if (run_ok && pred_valid) begin
        if (bypass) begin
          pred_counter <= upd_new;
          pred_taken   <= upd_new[1];
        end else begin
          pred_counter <= table_q[pred_idx];
          pred_taken   <= table_q[pred_idx][1];
        end
      end
    end
  end

endmodule
